// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the two-requester SRAM port arbiter.
package sram_port_arbiter_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 2;
    localparam int unsigned DEF_DATA_WIDTH = 8;

    // Controller states; encodings are fixed so waveforms line up across tools.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD1  = 2'd2,
        ST_RD2  = 2'd3
    } arb_state_e;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    // Requester id to one-hot grant vector.
    function automatic logic [1:0] id_to_onehot(input logic id);
        return (id == REQ_ID1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant decode; the last-grant register lives in the parent.
module rr_arbiter2
    import sram_port_arbiter_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant_c
);

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        o_grant_c = 2'b00;
        case (i_valid)
            2'b01:   o_grant_c = 2'b01;
            2'b10:   o_grant_c = 2'b10;
            2'b11:   o_grant_c = id_to_onehot(~i_last_grant);
            default: o_grant_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester controller in front of a single-port SRAM: round-robin
// arbitration, SRAM pin sequencing and read-data return.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_req0_valid,
    output logic                  o_req0_ready,
    input  logic                  i_req0_we,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    input  logic [DATA_WIDTH-1:0] i_req0_wdata,
    output logic                  o_req0_rvalid,
    output logic [DATA_WIDTH-1:0] o_req0_rdata,

    input  logic                  i_req1_valid,
    output logic                  o_req1_ready,
    input  logic                  i_req1_we,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    input  logic [DATA_WIDTH-1:0] i_req1_wdata,
    output logic                  o_req1_rvalid,
    output logic [DATA_WIDTH-1:0] o_req1_rdata,

    output logic                  o_busy,
    output logic                  o_sram_cs,
    output logic                  o_sram_we,
    output logic                  o_sram_oe,
    output logic [ADDR_WIDTH-1:0] o_sram_addr,
    inout  wire  [DATA_WIDTH-1:0] io_sram_data
);

    // DEPTH only exists to catch a mismatched SRAM instance at elaboration.
    if (DEPTH != (32'd1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("sram_port_arbiter: DEPTH must equal 2**ADDR_WIDTH");
    end

    arb_state_e            r_state;
    arb_state_e            w_next_state;
    logic                  w_accept;
    logic                  w_req0_ready;
    logic                  w_req1_ready;

    logic [1:0]            w_valid;
    logic [1:0]            w_grant;
    logic                  w_sel;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    logic                  r_last_grant;
    logic                  r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  r_cs;
    logic                  r_we_pin;
    logic                  r_oe;
    logic                  r_drive;
    logic                  r_busy;

    logic                  r_req0_rvalid;
    logic                  r_req1_rvalid;
    logic [DATA_WIDTH-1:0] r_req0_rdata;
    logic [DATA_WIDTH-1:0] r_req1_rdata;

    assign w_valid = {i_req1_valid, i_req0_valid};

    rr_arbiter2 u_rr (
        .i_valid      (w_valid),
        .i_last_grant (r_last_grant),
        .o_grant_c    (w_grant)
    );

    // Winner's request fields.
    assign w_sel       = w_grant[1];
    assign w_sel_we    = w_sel ? i_req1_we    : i_req0_we;
    assign w_sel_addr  = w_sel ? i_req1_addr  : i_req0_addr;
    assign w_sel_wdata = w_sel ? i_req1_wdata : i_req0_wdata;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode; ready only ever rises in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_grant) begin
                    w_accept     = 1'b1;
                    w_req0_ready = w_grant[0];
                    w_req1_ready = w_grant[1];
                    w_next_state = w_sel_we ? ST_WR : ST_RD1;
                end
            end
            ST_WR:   w_next_state = ST_IDLE;
            ST_RD1:  w_next_state = ST_RD2;
            ST_RD2:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Capture the accepted request and remember who was served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= REQ_ID1;
            r_id         <= REQ_ID0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_sel;
            r_id         <= w_sel;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
        end
    end

    // SRAM pins registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cs     <= 1'b0;
            r_we_pin <= 1'b0;
            r_oe     <= 1'b0;
            r_drive  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_cs     <= (w_next_state != ST_IDLE);
            r_we_pin <= (w_next_state == ST_WR);
            r_oe     <= (w_next_state == ST_RD1) || (w_next_state == ST_RD2);
            r_drive  <= (w_next_state == ST_WR);
            r_busy   <= (w_next_state != ST_IDLE);
        end
    end

    // Sample the bus at the end of RD2 and pulse rvalid to the issuing requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req0_rvalid <= 1'b0;
            r_req1_rvalid <= 1'b0;
            r_req0_rdata  <= '0;
            r_req1_rdata  <= '0;
        end else begin
            r_req0_rvalid <= (r_state == ST_RD2) && (r_id == REQ_ID0);
            r_req1_rvalid <= (r_state == ST_RD2) && (r_id == REQ_ID1);
            if (r_state == ST_RD2) begin
                if (r_id == REQ_ID0) begin
                    r_req0_rdata <= io_sram_data;
                end else begin
                    r_req1_rdata <= io_sram_data;
                end
            end
        end
    end

    assign o_req0_ready  = w_req0_ready;
    assign o_req1_ready  = w_req1_ready;
    assign o_req0_rvalid = r_req0_rvalid;
    assign o_req1_rvalid = r_req1_rvalid;
    assign o_req0_rdata  = r_req0_rdata;
    assign o_req1_rdata  = r_req1_rdata;
    assign o_busy        = r_busy;
    assign o_sram_cs     = r_cs;
    assign o_sram_we     = r_we_pin;
    assign o_sram_oe     = r_oe;
    assign o_sram_addr   = r_addr;
    assign io_sram_data  = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule
